// File: rtl/mem_port_master.sv
// mem_port_master: valid/ready load/store front end for a single-port synchronous word RAM.
// Partial stores become read-modify-write. Rev 1.0
`default_nettype none

module mem_port_master #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic              err_q;

    logic              accept;
    logic              range_err;
    logic [31:0]       merge_data;
    logic              unused_addr_bits;

    assign accept           = req_valid && req_ready;
    assign range_err        = |req_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^req_addr[1:0];

    // Lanes not enabled by the store keep the word's current RAM contents.
    always_comb begin
        merge_data = '0;
        for (int i = 0; i < 4; i++) begin
            merge_data[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_dout[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (range_err)
                        state_nxt = RESP;
                    else if (req_we && req_be == 4'hF)
                        state_nxt = WR;
                    else if (req_we && req_be == 4'h0)
                        state_nxt = RESP;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = RDW;
            RDW:     state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_we    = (state == WR);
        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) && err_q;
        rsp_rdata = ((state == RESP) && !we_q && !err_q) ? rdata_q : 32'h0;
        mem_addr  = addr_q;
        mem_din   = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        we_q    <= req_we;
                        err_q   <= range_err;
                    end
                end
                RDW: begin
                    if (we_q)
                        wdata_q <= merge_data;
                    else
                        rdata_q <= mem_dout;
                end
                RESP:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: directed self-checking bench with a behavioural synchronous RAM.
`default_nettype none

module tb_mem_port_master;

    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [3:0]        req_be = 4'h0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout = 32'h0;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;
    logic [ADDR_W-1:0] we_addr = '0;
    logic [31:0]       we_din = '0;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    mem_port_master #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: output register holds during write cycles.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        else        mem_dout <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
            we_din  = mem_din;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err);
        int guard;
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        check("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        int lat, w0, n;
        logic [31:0] rd;
        logic er;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", {19'h0, mem_addr}, 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full store then load
        w0 = we_cnt;
        xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er);
        check("fst_lat", lat, 2);
        check("fst_we_pulses", we_cnt - w0, 1);
        check("fst_we_addr", {19'h0, we_addr}, 32'd4);
        check("fst_we_din", we_din, 32'hDEADBEEF);
        check("fst_rdata", rd, 32'h0);
        check("fst_err", {31'h0, er}, 32'h0);
        xfer(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er);
        check("ld_lat", lat, 3);
        check("ld_rdata", rd, 32'hDEADBEEF);
        check("ld_err", {31'h0, er}, 32'h0);

        // Partial store (read-modify-write)
        w0 = we_cnt;
        xfer(1'b1, 4'b0010, 32'h10, 32'h00005500, lat, rd, er);
        check("pst_lat", lat, 4);
        check("pst_we_pulses", we_cnt - w0, 1);
        check("pst_we_din", we_din, 32'hDEAD55EF);
        check("pst_rdata", rd, 32'h0);
        xfer(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er);
        check("pst_readback", rd, 32'hDEAD55EF);

        // Out of range and empty stores
        w0 = we_cnt;
        xfer(1'b0, 4'h0, 32'h00008000, 32'h0, lat, rd, er);
        check("oor_ld_lat", lat, 1);
        check("oor_ld_err", {31'h0, er}, 32'h1);
        check("oor_ld_rdata", rd, 32'h0);
        xfer(1'b1, 4'hF, 32'h80000010, 32'h55555555, lat, rd, er);
        check("oor_st_lat", lat, 1);
        check("oor_st_err", {31'h0, er}, 32'h1);
        xfer(1'b1, 4'h0, 32'h10, 32'h12121212, lat, rd, er);
        check("be0_lat", lat, 1);
        check("be0_err", {31'h0, er}, 32'h0);
        check("oor_be0_no_we", we_cnt - w0, 0);
        xfer(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er);
        check("oor_no_alias", rd, 32'hDEAD55EF);

        // Back-to-back loads with req_valid held
        xfer(1'b1, 4'hF, 32'h0, 32'h11111111, lat, rd, er);
        xfer(1'b1, 4'hF, 32'h4, 32'h22222222, lat, rd, er);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy", {31'h0, req_ready}, 32'h0);
        req_addr = 32'h4;
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("b2b_lat1", n, 3);
        check("b2b_data1", rsp_rdata, 32'h11111111);
        @(negedge clk);
        check("b2b_idle_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        check("b2b_lat2", n, 3);
        check("b2b_data2", rsp_rdata, 32'h22222222);
        @(negedge clk);

        // Boundary word
        xfer(1'b1, 4'hF, 32'h00007FFC, 32'hCAFEF00D, lat, rd, er);
        check("bnd_we_addr", {19'h0, we_addr}, 32'd8191);
        check("bnd_err", {31'h0, er}, 32'h0);
        xfer(1'b0, 4'h0, 32'h00007FFC, 32'h0, lat, rd, er);
        check("bnd_readback", rd, 32'hCAFEF00D);

        // Reset in RDW of a partial store
        xfer(1'b1, 4'hF, 32'h20, 32'h12345678, lat, rd, er);
        w0 = we_cnt;
        n = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0001; req_addr = 32'h20; req_wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {31'h0, mem_we}, 32'h0);
        check("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
        check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        check("mid_rst_addr", {19'h0, mem_addr}, 32'h0);
        check("mid_rst_din", mem_din, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_we", we_cnt - w0, 0);
        check("mid_rst_no_rsp", rsp_cnt - n, 0);
        xfer(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er);
        check("mid_rst_word", rd, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
